// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage controller: decodes memory ops for the I/O mux, owns the
// call-stack pointer and aligns 1-cycle-latency read data into registered writeback outputs.
module mem_stage_ctrl #(
    parameter int unsigned STK_DEPTH_LOG2 = 8,
    parameter int unsigned RD_W           = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      valid_in,
    input  logic [2:0]                op,
    input  logic [1:0]                space,
    input  logic [16:0]               addr_in,
    input  logic [11:0]               wdata_in,
    input  logic [13:0]               ret_addr_in,
    input  logic [RD_W-1:0]           rd_in,
    output logic                      main_mem_en,
    output logic                      prog_mem_en,
    output logic                      fb_en,
    output logic                      call_stk_en,
    output logic                      mem_wen,
    output logic [16:0]               addr_out,
    output logic [STK_DEPTH_LOG2-1:0] call_stk_addr_out,
    output logic [11:0]               data_out,
    output logic [13:0]               call_stk_data_out,
    input  logic [11:0]               rdata_in,
    input  logic [13:0]               call_stk_rdata_in,
    output logic                      wb_valid,
    output logic [RD_W-1:0]           wb_rd,
    output logic [11:0]               wb_data,
    output logic                      ret_valid,
    output logic [13:0]               ret_addr,
    output logic [STK_DEPTH_LOG2:0]   sp,
    output logic                      prog_wr_fault,
    output logic                      stk_overflow,
    output logic                      stk_underflow
);

    typedef enum logic [2:0] {
        OpNop   = 3'b000,
        OpLoad  = 3'b001,
        OpStore = 3'b010,
        OpCall  = 3'b011,
        OpRet   = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        SpcMain = 2'b00,
        SpcProg = 2'b01,
        SpcFb   = 2'b10,
        SpcRsvd = 2'b11
    } space_e;

    // Kind of the op in flight between request and capture.
    typedef enum logic [2:0] {
        KindNone,
        KindLoad,
        KindLoadZero,
        KindRet,
        KindRetZero
    } kind_e;

    localparam logic [STK_DEPTH_LOG2:0] SpOne = {{STK_DEPTH_LOG2{1'b0}}, 1'b1};

    logic [STK_DEPTH_LOG2:0] sp_q, sp_d, sp_dec;
    logic                    sp_full, sp_empty;
    kind_e                   kind_q, kind_d;
    logic [RD_W-1:0]         rd_q;

    logic                    wb_valid_q;
    logic [RD_W-1:0]         wb_rd_q;
    logic [11:0]             wb_data_q;
    logic                    ret_valid_q;
    logic [13:0]             ret_addr_q;

    logic                    prog_wr_fault_q, stk_overflow_q, stk_underflow_q;
    logic                    prog_fault_set, overflow_set, underflow_set;
    logic                    is_store;

    // Occupancy never exceeds depth, so the MSB alone marks a full stack.
    assign sp_full  = sp_q[STK_DEPTH_LOG2];
    assign sp_empty = (sp_q == '0);
    assign sp_dec   = sp_q - SpOne;
    assign is_store = (op == OpStore);

    always_comb begin
        main_mem_en       = 1'b0;
        prog_mem_en       = 1'b0;
        fb_en             = 1'b0;
        call_stk_en       = 1'b0;
        mem_wen           = 1'b0;
        call_stk_addr_out = '0;
        addr_out          = '0;
        data_out          = '0;
        call_stk_data_out = '0;
        kind_d            = KindNone;
        sp_d              = sp_q;
        prog_fault_set    = 1'b0;
        overflow_set      = 1'b0;
        underflow_set     = 1'b0;

        if (reset_n) begin
            addr_out          = addr_in;
            data_out          = wdata_in;
            call_stk_data_out = ret_addr_in;
        end

        if (valid_in && reset_n) begin
            case (op)
                OpLoad, OpStore: begin
                    case (space)
                        SpcMain: begin
                            main_mem_en = 1'b1;
                            mem_wen     = is_store;
                        end
                        SpcProg: begin
                            if (is_store) begin
                                prog_fault_set = 1'b1;
                            end else begin
                                prog_mem_en = 1'b1;
                            end
                        end
                        SpcFb: begin
                            fb_en   = 1'b1;
                            mem_wen = is_store;
                        end
                        default: ;
                    endcase
                    if (!is_store) begin
                        kind_d = (space == SpcRsvd) ? KindLoadZero : KindLoad;
                    end
                end
                OpCall: begin
                    if (sp_full) begin
                        overflow_set = 1'b1;
                    end else begin
                        call_stk_en       = 1'b1;
                        mem_wen           = 1'b1;
                        call_stk_addr_out = sp_q[STK_DEPTH_LOG2-1:0];
                        sp_d              = sp_q + SpOne;
                    end
                end
                OpRet: begin
                    if (sp_empty) begin
                        underflow_set = 1'b1;
                        kind_d        = KindRetZero;
                    end else begin
                        call_stk_en       = 1'b1;
                        call_stk_addr_out = sp_dec[STK_DEPTH_LOG2-1:0];
                        sp_d              = sp_dec;
                        kind_d            = KindRet;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_q            <= '0;
            kind_q          <= KindNone;
            rd_q            <= '0;
            prog_wr_fault_q <= 1'b0;
            stk_overflow_q  <= 1'b0;
            stk_underflow_q <= 1'b0;
        end else begin
            sp_q            <= sp_d;
            kind_q          <= kind_d;
            rd_q            <= rd_in;
            prog_wr_fault_q <= prog_wr_fault_q | prog_fault_set;
            stk_overflow_q  <= stk_overflow_q | overflow_set;
            stk_underflow_q <= stk_underflow_q | underflow_set;
        end
    end

    // Capture stage: read data arrives the cycle after the request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            ret_valid_q <= 1'b0;
            ret_addr_q  <= '0;
        end else begin
            wb_valid_q  <= (kind_q == KindLoad) || (kind_q == KindLoadZero);
            ret_valid_q <= (kind_q == KindRet) || (kind_q == KindRetZero);
            if (kind_q == KindLoad) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= rdata_in;
            end else if (kind_q == KindLoadZero) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= '0;
            end
            if (kind_q == KindRet) begin
                ret_addr_q <= call_stk_rdata_in;
            end else if (kind_q == KindRetZero) begin
                ret_addr_q <= '0;
            end
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign ret_valid     = ret_valid_q;
    assign ret_addr      = ret_addr_q;
    assign sp            = sp_q;
    assign prog_wr_fault = prog_wr_fault_q;
    assign stk_overflow  = stk_overflow_q;
    assign stk_underflow = stk_underflow_q;

endmodule
